// File: rtl/noc_pkg.sv
// Shared router definitions: port indices, the "no owner" select code and
// the output-port arbiter state encoding.
package noc_pkg;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_idx_t;

    localparam logic [2:0] SEL_NONE = 3'b111;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// scanning upward modulo NPORTS.
module rr_pick
    import noc_pkg::*;
#(
    parameter int unsigned NPORTS = 5
) (
    input  logic [NPORTS-1:0] req,
    input  logic [2:0]        ptr,
    output logic [NPORTS-1:0] win,
    output logic [2:0]        win_idx
);

    localparam logic [3:0] NP = 4'(NPORTS);

    logic [3:0] pos;
    logic       found;

    always_comb begin
        win     = '0;
        win_idx = SEL_NONE;
        found   = 1'b0;
        pos     = '0;
        for (int unsigned off = 0; off < NPORTS; off++) begin
            pos = {1'b0, ptr} + 4'(off);
            if (pos >= NP) begin
                pos = pos - NP;
            end
            if (!found && req[pos[2:0]]) begin
                found             = 1'b1;
                win[pos[2:0]]     = 1'b1;
                win_idx           = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/outport_arb.sv
// Wormhole output-port arbiter: a round-robin winner owns the port until
// its tail flit transfers; the output flit is muxed from the owner's input.
module outport_arb
    import noc_pkg::*;
#(
    parameter int unsigned NPORTS = 5,
    parameter int unsigned FLIT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        tail,
    input  logic [NPORTS*FLIT_W-1:0] in_data,
    input  logic                     out_ready,
    output logic [NPORTS-1:0]        grant,
    output logic [2:0]               sel,
    output logic                     out_valid,
    output logic [FLIT_W-1:0]        out_data,
    output logic [NPORTS-1:0]        pop
);

    arb_state_t        state;
    logic [2:0]        ptr;
    logic [NPORTS-1:0] win;
    logic [2:0]        win_idx;
    logic              xfer;
    logic              owner_tail;

    rr_pick #(.NPORTS(NPORTS)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx)
    );

    // grant is zero when free, so masking by grant also forces idle outputs low.
    always_comb begin
        out_valid  = |(req & grant);
        owner_tail = |(tail & grant);
        xfer       = out_valid & out_ready;
        pop        = xfer ? grant : '0;
        out_data   = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (grant[i]) begin
                out_data = in_data[i*FLIT_W +: FLIT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
            grant <= '0;
            sel   <= SEL_NONE;
            ptr   <= LOCAL;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        state <= ARB_LOCKED;
                        grant <= win;
                        sel   <= win_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (xfer && owner_tail) begin
                        state <= ARB_IDLE;
                        grant <= '0;
                        sel   <= SEL_NONE;
                        ptr   <= (sel == 3'(NPORTS - 1)) ? LOCAL : sel + 3'd1;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= '0;
                    sel   <= SEL_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_outport_arb.sv
// Randomized scoreboard bench for outport_arb against a packet-level
// reference model of wormhole round-robin arbitration.
module tb_outport_arb;

    localparam int NP = 5;
    localparam int FW = 8;
    localparam int NCYC = 4000;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   req;
    logic [NP-1:0]   tail;
    logic [NP*FW-1:0] in_data;
    logic            out_ready;
    logic [NP-1:0]   grant;
    logic [2:0]      sel;
    logic            out_valid;
    logic [FW-1:0]   out_data;
    logic [NP-1:0]   pop;

    always #5 clk = ~clk;

    outport_arb #(.NPORTS(NP), .FLIT_W(FW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .tail      (tail),
        .in_data   (in_data),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .pop       (pop)
    );

    typedef struct {
        int         port;
        logic [7:0] data;
    } xfer_t;

    xfer_t      exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    // Reference model: owner of the port (-1 = free), rotation start, and
    // per-port packet sources (flits remaining in current packet, head flit).
    int         owner   = -1;
    int         rr_ptr  = 0;
    int         rem[NP];
    logic [7:0] flit[NP];
    int         xfer_port = -1;
    bit         xfer_tail = 1'b0;
    bit         skip_step = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        if (xfer_port >= 0) begin
            rem[xfer_port]--;
            flit[xfer_port] = 8'($urandom);
            if (xfer_tail) begin
                rr_ptr = (xfer_port + 1) % NP;
                owner  = -1;
            end
        end else if (owner < 0 && req != '0) begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (rr_ptr + k) % NP;
                if (req[p]) begin
                    owner = p;
                    break;
                end
            end
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < NP; i++) begin
            if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
                rem[i]  = int'($urandom_range(1, 4));
                flit[i] = 8'($urandom);
            end
            req[i]  = (rem[i] != 0) && ($urandom_range(0, 4) != 0);
            tail[i] = (rem[i] == 1);
            in_data[i*FW +: FW] = flit[i];
        end
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Monitor: every DUT transfer must match the oldest expected transfer.
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk);
            if (pop != '0 || exp_q.size() != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 64'(pop), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pop", 64'(pop), 64'd1 << e.port);
                    check("xfer_data", 64'(out_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        bit do_rst;
        for (int i = 0; i < NP; i++) begin
            rem[i]  = 0;
            flit[i] = 8'($urandom);
        end
        reset     = 1'b0;
        req       = '0;
        tail      = '0;
        in_data   = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_sel", 64'(sel), 64'h7);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_pop", 64'(pop), 64'd0);

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (!skip_step) model_step();
            skip_step = 1'b0;
            xfer_port = -1;
            do_rst    = ($urandom_range(0, 99) == 0);
            drive_sources();
            if (do_rst) begin
                reset     = 1'b0;
                owner     = -1;
                rr_ptr    = 0;
                skip_step = 1'b1;
                #1;
                check("async_rst_grant", 64'(grant), 64'd0);
                check("async_rst_sel", 64'(sel), 64'h7);
                check("async_rst_valid", 64'(out_valid), 64'd0);
            end else begin
                reset = 1'b1;
                if (owner >= 0 && req[owner] && out_ready) begin
                    xfer_port = owner;
                    xfer_tail = tail[owner];
                    exp_q.push_back('{owner, flit[owner]});
                end
            end
            @(negedge clk);
            check("grant", 64'(grant), (owner >= 0) ? (64'd1 << owner) : 64'd0);
            check("sel", 64'(sel), (owner >= 0) ? 64'(owner) : 64'h7);
            check("out_valid", 64'(out_valid),
                  (owner >= 0 && req[owner]) ? 64'd1 : 64'd0);
            if (owner >= 0) check("out_data", 64'(out_data), 64'(flit[owner]));
        end

        @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/outport_arb.md
OUTPORT_ARB -- requirements
Module: outport_arb

Interface
REQ-001 Parameter NPORTS, default 5, number of input ports competing for this output port (local, N, E, S, W = 0..4).
REQ-002 Parameter FLIT_W, default 8, flit data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
REQ-005 req  input  NPORTS  bit i = input port i's route computation selects this output port for its current flit.
REQ-006 tail  input  NPORTS  bit i = input port i's current flit is the last flit of its packet.
REQ-007 in_data  input  NPORTS*FLIT_W  flit of port i at bits [i*FLIT_W +: FLIT_W].
REQ-008 out_ready  input  1  downstream link accepts a flit this cycle.
REQ-009 grant  output  NPORTS  one-hot owner of the output port; all zero when free.
REQ-010 sel  output  3  encoded owner index 0..4; 3'b111 when free.
REQ-011 out_valid  output  1  a flit is presented on out_data.
REQ-012 out_data  output  FLIT_W  flit of the owning port, muxed combinationally from in_data.
REQ-013 pop  output  NPORTS  one-hot; bit i high = port i's flit transferred this cycle (input dequeues it).

Function
REQ-014 Two states: IDLE (no owner) and LOCKED (owner held until its tail flit transfers; wormhole).
REQ-015 IDLE with req != 0: registered round-robin pick; first requesting port at or after ptr, scanning upward mod NPORTS; next cycle state = LOCKED, grant/sel = winner.
REQ-016 IDLE with req == 0: stay IDLE; grant = 0, sel = 3'b111.
REQ-017 Arbitration latency: request seen at edge N yields grant visible after edge N+1 (one cycle).
REQ-018 LOCKED: out_valid = req[owner]; out_data = in_data slice of owner; other ports' req ignored.
REQ-019 Transfer occurs in a cycle where out_valid and out_ready are both high; pop[owner] = 1 that cycle only.
REQ-020 Transfer with tail[owner] = 1: next state IDLE, grant = 0, sel = 3'b111, ptr = (owner+1) mod NPORTS.
REQ-021 Transfer with tail[owner] = 0: remain LOCKED, same owner.
REQ-022 Owner drops req mid-packet (bubble): remain LOCKED, out_valid = 0, no pop; no other port may take the output.
REQ-023 out_ready low: hold, no pop, out_data remains owner's input flit.
REQ-024 Single-flit packet (head with tail): LOCKED for exactly one transfer cycle, then IDLE.
REQ-025 Release cycle: no new grant in same cycle; competing requests arbitrate in IDLE on next edge (one-cycle bubble between packets).
REQ-026 ptr updates only on packet completion, never on grant.
REQ-027 pop, out_valid are zero in IDLE; grant is always one-hot or zero.

Reset
REQ-028 Reset low: state = IDLE, grant = 0, sel = 3'b111, ptr = 0, out_valid = 0, pop = 0, regardless of an in-progress packet.
REQ-029 After reset release, first arbitration occurs on the first edge with reset high and req != 0.

Structure
REQ-030 Shared package noc_pkg holds port indices (LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4), SEL_NONE = 3'b111, and the IDLE/LOCKED state encoding.
REQ-031 One combinational sub-module rr_pick(req, ptr) -> one-hot winner and index, instantiated once.
REQ-032 Output mux and state/pointer registers live in outport_arb; no other sub-modules.

Verification
REQ-033 Reset low mid-packet (owner 2, LOCKED) -> grant = 0, sel = 3'b111, out_valid = 0 immediately; after release req=5'b00100 re-granted from ptr=0.
REQ-034 ptr=0, req=5'b10110 for three single-flit packets, out_ready=1 -> grants in order port 1, 2, 4, each one transfer, one idle cycle between.
REQ-035 Owner 3, 4-flit packet, tail on flit 4, req[0] high throughout -> port 0 granted only after flit 4 pops; pop[3] exactly 4 times.
REQ-036 Owner 1, out_ready low 3 cycles then high -> no pop during stall, out_data stable = in_data port 1, one pop when ready returns.
REQ-037 Owner 4 drops req for 2 cycles mid-packet, req[0] high -> out_valid = 0, grant stays 5'b10000, port 0 not granted until port 4's tail pops.
REQ-038 ptr=4 after port 3 completes, req=5'b01001 -> port 0 wins (wrap-around), then ptr = 1.
